hamming_encoder: RTL

HAMMING_ENCODER -- requirements
Module: hamming_encoder

---
 rtl/hamming_encoder.sv | 100 ++++++++++
 1 files changed

// File: rtl/hamming_encoder.sv
// Byte-serial extended Hamming(16,11) encoder.
// Takes two message bytes in and returns two codeword bytes, with a sticky error flag and a count of codewords sent.
module hamming_encoder #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Clear,
   input  logic [7:0]       In_data,
   input  logic             In_valid,
   output logic             In_ready,
   output logic [7:0]       Out_data,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [CNT_W-1:0] Word_cnt,
   output logic             Hi_err
);

   typedef enum logic [1:0] {IN_LO, IN_HI, OUT_LO, OUT_HI} state_t;

   state_t           state_q;
   logic [7:0]       lo_q;
   logic [15:0]      cw_q;
   logic [15:0]      cw_d;
   logic [7:0]       out_data_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic             hi_err_q;
   logic             in_fire;
   logic             out_fire;

   // m[0] is d1: parity bits sit at the power-of-two positions, and p0 covers the whole word.
   function automatic logic [15:0] encode(input logic [10:0] m);
      logic [11:1] d;
      logic        p8, p4, p2, p1, p0;
      d  = m;
      p8 = ^d[11:5];
      p4 = (^d[11:8]) ^ (^d[4:2]);
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
      return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
   endfunction

   assign cw_d     = encode({In_data[2:0], lo_q});
   assign in_fire  = In_valid & in_ready_q;
   assign out_fire = Out_ready & out_valid_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IN_LO;
         lo_q        <= '0;
         cw_q        <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         hi_err_q    <= 1'b0;
      end else begin
         case (state_q)
            IN_LO: if (in_fire) begin
               lo_q    <= In_data;
               state_q <= IN_HI;
            end
            IN_HI: if (in_fire) begin
               cw_q        <= cw_d;
               out_data_q  <= cw_d[7:0];
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= OUT_LO;
               if (|In_data[7:3]) hi_err_q <= 1'b1;
            end
            OUT_LO: if (out_fire) begin
               out_data_q <= cw_q[15:8];
               state_q    <= OUT_HI;
            end
            OUT_HI: if (out_fire) begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= IN_LO;
               cnt_q       <= cnt_q + 1'b1;
            end
            default: state_q <= IN_LO;
         endcase
         // Clear overrides any increment or error set on the same edge.
         if (Clear) begin
            cnt_q    <= '0;
            hi_err_q <= 1'b0;
         end
      end
   end

   assign In_ready  = in_ready_q;
   assign Out_valid = out_valid_q;
   assign Out_data  = out_data_q;
   assign Word_cnt  = cnt_q;
   assign Hi_err    = hi_err_q;

endmodule
